ws2812_chain_driver: RTL and testbench
======================================

// Module: ws2812_chain_driver
// PURPOSE
//  Parametrised WS2812B strip driver: streams NUM_LEDS 24-bit {R,G,B} pixels in from a
//  valid/ready source, applies frame-global brightness scaling, reorders to G,R,B MSB-first
//  and emits the single-wire NRZ waveform plus the latch low period. Sits between the
//  pattern/frame generator and the LED data pin; replaces the single-pixel led_driver.
// PARAMETERS
//  NUM_LEDS    8     pixels per frame (>=1)
//  T0H         19    clk cycles dout high for a '0' bit (48 MHz: ~0.4 us)
//  T1H         38    clk cycles dout high for a '1' bit (~0.8 us)
//  TBIT        60    clk cycles per bit period; requires T0H < T1H < TBIT
//  TRESET      3840  clk cycles dout held low after last bit (latch, ~80 us)
// PORTS
//  clk        in   1   system clock
//  rst        in   1   synchronous reset, active-low (0 = reset)
//  start      in   1   1-cycle pulse: begin a frame; ignored while busy=1
//  bright     in   8   brightness, sampled on accepted start; 255 = full scale
//  pix_data   in   24  pixel {R[23:16],G[15:8],B[7:0]}
//  pix_valid  in   1   pix_data valid
//  pix_ready  out  1   driver accepts pix_data this cycle (transfer = valid & ready)
//  dout       out  1   WS2812 serial data line
//  busy       out  1   frame in progress (start accepted through end of latch)
//  done       out  1   1-cycle pulse on last cycle of latch period
//  underrun   out  1   1-cycle pulse: next pixel not available when needed; frame aborted
// BEHAVIOUR
//  Reset (rst=0 at clk edge): state IDLE; dout=0, busy=0, done=0, underrun=0, pix_ready=0,
//   counters cleared, holding register empty. Applies mid-frame: line drops low next edge.
//  FSM: IDLE -> FETCH -> BIT_HI -> BIT_LO -> (BIT_HI | FETCH | LATCH) -> IDLE.
//  IDLE: start=1 -> latch bright into bright_q, px_cnt=0, go FETCH; busy=1 from next cycle.
//  Pixel path: one holding register (hold, hold_full) + 24-bit shift register.
//   pix_ready = busy & !hold_full & (accepted count < NUM_LEDS) & !aborted.
//   Transfer writes hold; each channel scaled: c' = (c*(bright_q+1))>>8 (16-bit product,
//   keep bits [15:8]); bright_q=255 -> identity, 0 -> all zero. Stored reordered {G',R',B'}.
//  FETCH: wait (dout=0) until hold_full; then shift reg <= hold, hold_full<=0, bit_idx=23,
//   go BIT_HI. No deadline for the first pixel of a frame.
//  BIT_HI: dout=1 for T0H (bit=0) or T1H (bit=1) cycles, then BIT_LO.
//  BIT_LO: dout=0 for remaining cycles so the bit period is exactly TBIT cycles.
//   End of BIT_LO with bit_idx>0: bit_idx--, next bit, BIT_HI (no gap cycles).
//   End of bit 0, px_cnt<NUM_LEDS-1: if hold_full -> load next pixel, BIT_HI directly
//   (no gap between pixels); else underrun=1 for one cycle, abort, go LATCH.
//   End of bit 0, px_cnt==NUM_LEDS-1: go LATCH.
//  LATCH: dout=0 for exactly TRESET cycles; done=1 on the last; then IDLE, busy=0.
//   done also pulses after an aborted frame. Pixels offered after abort are not accepted.
//  Total frame time (no stalls): NUM_LEDS*24*TBIT + TRESET cycles from first bit.
//  start during busy: ignored, no effect on bright_q. start coincident with done: ignored;
//   start in the cycle after done (IDLE) accepted.
//  Extra pixels beyond NUM_LEDS are never accepted (pix_ready=0).
// TESTING  (NUM_LEDS=2, T0H=2, T1H=4, TBIT=6, TRESET=10)
//  1 Reset: rst=0 for 2 cycles mid-bit -> dout=0, busy=0, pix_ready=0 next edge.
//  2 Frame, bright=255, pixels 24'hFF0000, 24'h0000FF held valid -> bits G=00,R=FF,B=00
//    then 00,00,FF: high widths 2/4 cycles per bit, each bit 6 cycles, 288 cycles of bits,
//    10 low cycles, one done pulse, busy=0 after.
//  3 bright=127, pixel 24'h00CEFF -> transmitted GRB = 8'h67,8'h00,8'h7F.
//  4 Second pixel withheld -> underrun pulse at end of pixel 0 bit 0, dout low 10 cycles,
//    done pulses, later pix_valid not accepted.
//  5 start pulsed mid-frame and bright changed -> frame timing and scaling unchanged.
//  6 start in cycle after done -> new frame begins, pix_ready rises, no lost cycle.

Source files
------------

// File: rtl/ws2812_chain_driver.sv
// WS2812B chain driver: accepts NUM_LEDS {R,G,B} pixels over valid/ready, scales each channel
// by a frame-global brightness, reorders to G,R,B and serialises them MSB-first as NRZ pulses,
// followed by a latch low period.
module ws2812_chain_driver #(
    parameter int unsigned NUM_LEDS = 8,
    parameter int unsigned T0H      = 19,
    parameter int unsigned T1H      = 38,
    parameter int unsigned TBIT     = 60,
    parameter int unsigned TRESET   = 3840
) (
    input  logic        i_clk,
    input  logic        i_rst,
    input  logic        i_start,
    input  logic [7:0]  i_bright,
    input  logic [23:0] i_pix_data,
    input  logic        i_pix_valid,
    output logic        o_pix_ready,
    output logic        o_dout,
    output logic        o_busy,
    output logic        o_done,
    output logic        o_underrun
);

    localparam int unsigned CNT_MAX = (TBIT > TRESET) ? TBIT : TRESET;
    localparam int unsigned CW      = $clog2(CNT_MAX + 1);
    localparam int unsigned PW      = $clog2(NUM_LEDS + 1);

    localparam logic [CW-1:0] C_T0H_M1    = CW'(T0H - 1);
    localparam logic [CW-1:0] C_T1H_M1    = CW'(T1H - 1);
    localparam logic [CW-1:0] C_TBIT_M1   = CW'(TBIT - 1);
    localparam logic [CW-1:0] C_TRESET_M1 = CW'(TRESET - 1);
    localparam logic [CW-1:0] C_TRESET_M2 = CW'(TRESET - 2);
    localparam logic [PW-1:0] C_NUM       = PW'(NUM_LEDS);
    localparam logic [PW-1:0] C_LAST_PX   = PW'(NUM_LEDS - 1);
    // A one-cycle latch has its done pulse on the very first latch cycle.
    localparam logic          DONE_ON_ENTRY = (TRESET == 1);

    typedef enum logic [2:0] {
        StIdle,
        StFetch,
        StBitHi,
        StBitLo,
        StLatch
    } state_t;

    state_t         r_state;
    logic [7:0]     r_bright;
    logic [23:0]    r_hold;
    logic           r_hold_full;
    logic [23:0]    r_shift;
    logic [4:0]     r_bit_idx;
    logic [PW-1:0]  r_px_cnt;
    logic [PW-1:0]  r_acc_cnt;
    logic [CW-1:0]  r_cnt;
    logic           r_aborted;
    logic           r_dout;
    logic           r_busy;
    logic           r_done;
    logic           r_underrun;

    logic           w_pix_ready;
    logic           w_xfer;
    logic [23:0]    w_scaled;
    logic           w_hi_end;

    // c' = (c * (bright + 1)) >> 8, so 255 is identity and 0 blanks the channel.
    function automatic logic [7:0] scale(input logic [7:0] c, input logic [7:0] b);
        logic [15:0] prod;
        prod = {8'd0, c} * ({8'd0, b} + 16'd1);
        return prod[15:8];
    endfunction

    // Accept handshake, brightness scaling with GRB reorder, and end of the high phase.
    always_comb begin
        w_pix_ready = r_busy & ~r_hold_full & (r_acc_cnt < C_NUM) & ~r_aborted;
        w_xfer      = w_pix_ready & i_pix_valid;
        w_scaled    = {scale(i_pix_data[15:8], r_bright),
                       scale(i_pix_data[23:16], r_bright),
                       scale(i_pix_data[7:0], r_bright)};
        w_hi_end    = r_shift[23] ? (r_cnt == C_T1H_M1) : (r_cnt == C_T0H_M1);
    end

    // Frame FSM: holding register, bit timing, latch period and registered outputs.
    always_ff @(posedge i_clk) begin
        if (!i_rst) begin
            r_state     <= StIdle;
            r_bright    <= 8'd0;
            r_hold      <= 24'd0;
            r_hold_full <= 1'b0;
            r_shift     <= 24'd0;
            r_bit_idx   <= 5'd0;
            r_px_cnt    <= '0;
            r_acc_cnt   <= '0;
            r_cnt       <= '0;
            r_aborted   <= 1'b0;
            r_dout      <= 1'b0;
            r_busy      <= 1'b0;
            r_done      <= 1'b0;
            r_underrun  <= 1'b0;
        end else begin
            r_done     <= 1'b0;
            r_underrun <= 1'b0;
            if (w_xfer) begin
                r_hold      <= w_scaled;
                r_hold_full <= 1'b1;
                r_acc_cnt   <= r_acc_cnt + 1'b1;
            end
            case (r_state)
                StIdle: begin
                    if (i_start) begin
                        r_bright  <= i_bright;
                        r_px_cnt  <= '0;
                        r_acc_cnt <= '0;
                        r_aborted <= 1'b0;
                        r_busy    <= 1'b1;
                        r_cnt     <= '0;
                        r_state   <= StFetch;
                    end
                end
                StFetch: begin
                    // First pixel of a frame has no deadline.
                    if (r_hold_full) begin
                        r_shift     <= r_hold;
                        r_hold_full <= 1'b0;
                        r_bit_idx   <= 5'd23;
                        r_cnt       <= '0;
                        r_dout      <= 1'b1;
                        r_state     <= StBitHi;
                    end
                end
                StBitHi: begin
                    r_cnt <= r_cnt + 1'b1;
                    if (w_hi_end) begin
                        r_dout  <= 1'b0;
                        r_state <= StBitLo;
                    end
                end
                StBitLo: begin
                    if (r_cnt == C_TBIT_M1) begin
                        r_cnt <= '0;
                        if (r_bit_idx != 5'd0) begin
                            r_bit_idx <= r_bit_idx - 1'b1;
                            r_shift   <= {r_shift[22:0], 1'b0};
                            r_dout    <= 1'b1;
                            r_state   <= StBitHi;
                        end else if (r_px_cnt != C_LAST_PX) begin
                            if (r_hold_full) begin
                                r_shift     <= r_hold;
                                r_hold_full <= 1'b0;
                                r_bit_idx   <= 5'd23;
                                r_px_cnt    <= r_px_cnt + 1'b1;
                                r_dout      <= 1'b1;
                                r_state     <= StBitHi;
                            end else begin
                                r_underrun <= 1'b1;
                                r_aborted  <= 1'b1;
                                r_done     <= DONE_ON_ENTRY;
                                r_state    <= StLatch;
                            end
                        end else begin
                            r_done  <= DONE_ON_ENTRY;
                            r_state <= StLatch;
                        end
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                    end
                end
                StLatch: begin
                    if (r_cnt == C_TRESET_M1) begin
                        r_cnt   <= '0;
                        r_busy  <= 1'b0;
                        r_state <= StIdle;
                    end else begin
                        r_cnt <= r_cnt + 1'b1;
                        // Registered done lands on the final latch cycle.
                        if (!DONE_ON_ENTRY && (r_cnt == C_TRESET_M2)) begin
                            r_done <= 1'b1;
                        end
                    end
                end
                default: r_state <= StIdle;
            endcase
        end
    end

    assign o_pix_ready = w_pix_ready;
    assign o_dout      = r_dout;
    assign o_busy      = r_busy;
    assign o_done      = r_done;
    assign o_underrun  = r_underrun;

endmodule

// File: tb/tb_ws2812_chain_driver.sv
// Bench for ws2812_chain_driver: random pixels and brightness, expected NRZ waveform derived
// from the scaled GRB words, latch timing, underrun abort and start filtering.
module tb_ws2812_chain_driver;

    localparam int NUM    = 2;
    localparam int T0H    = 2;
    localparam int T1H    = 4;
    localparam int TBIT   = 6;
    localparam int TRESET = 10;

    logic        clk = 1'b0;
    logic        rst_n = 1'b0;
    logic        start = 1'b0;
    logic [7:0]  bright = 8'd0;
    logic [23:0] pix_data = 24'd0;
    logic        pix_valid = 1'b0;
    logic        o_pix_ready, o_dout, o_busy, o_done, o_underrun;

    int total = 0;
    int bad = 0;

    logic [23:0] src[$];
    logic [23:0] dir[$];
    int          src_idx = 0;
    int          acc_tb = 0;

    always #5 clk = ~clk;

    ws2812_chain_driver #(
        .NUM_LEDS(NUM), .T0H(T0H), .T1H(T1H), .TBIT(TBIT), .TRESET(TRESET)
    ) dut (
        .i_clk(clk), .i_rst(rst_n), .i_start(start), .i_bright(bright),
        .i_pix_data(pix_data), .i_pix_valid(pix_valid), .o_pix_ready(o_pix_ready),
        .o_dout(o_dout), .o_busy(o_busy), .o_done(o_done), .o_underrun(o_underrun)
    );

    function automatic logic [7:0] scl(input logic [7:0] c, input logic [7:0] b);
        int v;
        v = (int'(c) * (int'(b) + 1)) >> 8;
        return v[7:0];
    endfunction

    function automatic logic [23:0] to_grb(input logic [23:0] p, input logic [7:0] b);
        return {scl(p[15:8], b), scl(p[23:16], b), scl(p[7:0], b)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        total++;
        assert (obs === exp) else begin
            bad++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    // One clock: note whether a pixel transferred at this edge, then advance the source.
    task automatic step();
        bit x;
        x = (o_pix_ready === 1'b1) && pix_valid;
        @(posedge clk);
        #1;
        if (x) begin
            src_idx++;
            acc_tb++;
        end
        pix_valid = (src_idx < src.size());
        pix_data  = pix_valid ? src[src_idx] : 24'd0;
    endtask

    task automatic run_frame(input logic [7:0] br, input int navail, input bit poke,
                             input bit sdone);
        int          ntx;
        bit          ab;
        bit          bv;
        int          th;
        logic [23:0] words[$];
        logic [23:0] p;
        src.delete();
        src_idx = 0;
        acc_tb  = 0;
        for (int i = 0; i < navail; i++) begin
            p = (i < dir.size()) ? dir[i] : 24'($urandom);
            src.push_back(p);
        end
        dir.delete();
        ab  = (navail < NUM);
        ntx = ab ? navail : NUM;
        for (int i = 0; i < ntx; i++) words.push_back(to_grb(src[i], br));
        pix_valid = (src.size() > 0);
        pix_data  = pix_valid ? src[0] : 24'd0;

        start = 1'b1; bright = br;
        step();
        start = 1'b0;
        chk("start_busy_ready", {29'd0, o_busy, o_pix_ready, o_dout}, 32'b110);
        if (poke) begin
            start = 1'b1; bright = ~br;
        end
        step();
        start = 1'b0; bright = 8'($urandom);
        chk("fetch_wait", {31'd0, o_dout}, 32'd0);
        step();

        for (int k = 0; k < ntx * 24 * TBIT; k++) begin
            bv = words[k / (24 * TBIT)][23 - ((k / TBIT) % 24)];
            th = bv ? T1H : T0H;
            chk("bit_wave", {28'd0, o_dout, o_busy, o_done, o_underrun},
                {28'd0, ((k % TBIT) < th), 1'b1, 1'b0, 1'b0});
            if (poke && k == 100) begin
                start = 1'b1; bright = 8'h00;
            end
            step();
            start = 1'b0;
        end

        for (int j = 0; j < TRESET; j++) begin
            chk("latch", {27'd0, o_dout, o_busy, o_done, o_underrun, o_pix_ready},
                {27'd0, 1'b0, 1'b1, (j == TRESET - 1), (ab && j == 0), 1'b0});
            if (ab && j == 2) src.push_back(24'($urandom));
            if (sdone && j == TRESET - 1) begin
                start = 1'b1; bright = 8'h00;
            end
            step();
            start = 1'b0;
        end
        chk("accepted", acc_tb, ntx);
        chk("idle_after", {29'd0, o_busy, o_done, o_dout}, 32'd0);
        if (sdone) begin
            step();
            chk("start_at_done_ignored", {30'd0, o_busy, o_pix_ready}, 32'd0);
        end
    endtask

    initial begin
        // Power-up reset.
        rst_n = 1'b0;
        step();
        step();
        chk("reset", {27'd0, o_dout, o_busy, o_done, o_underrun, o_pix_ready}, 32'd0);
        rst_n = 1'b1;
        step();
        chk("reset_release", {29'd0, o_dout, o_busy, o_pix_ready}, 32'd0);

        // Full-scale frame with directed colours.
        dir = {24'hFF0000, 24'h0000FF};
        run_frame(8'hFF, 2, 1'b0, 1'b0);

        // Half brightness, plus an extra pixel that must not be accepted.
        dir = {24'h00CEFF};
        run_frame(8'd127, 3, 1'b0, 1'b0);

        // Second pixel withheld: underrun and abort.
        run_frame(8'($urandom), 1, 1'b0, 1'b0);

        // start with a new brightness while busy has no effect.
        run_frame(8'($urandom), 2, 1'b1, 1'b0);

        // start coincident with done is ignored.
        run_frame(8'($urandom), 2, 1'b0, 1'b1);

        // Back-to-back: second frame starts in the cycle after done.
        run_frame(8'($urandom), 3, 1'b0, 1'b0);
        run_frame(8'($urandom), 2, 1'b0, 1'b0);

        // Reset in the middle of a bit.
        src.delete();
        src.push_back(24'hFFFFFF);
        src.push_back(24'($urandom));
        src_idx = 0;
        pix_valid = 1'b1; pix_data = src[0];
        start = 1'b1; bright = 8'hFF;
        step();
        start = 1'b0;
        for (int n = 0; n < 20; n++) begin
            if (o_dout === 1'b1) break;
            step();
        end
        chk("reached_bit", {31'd0, o_dout}, 32'd1);
        step();
        rst_n = 1'b0;
        step();
        chk("rst_mid_1", {29'd0, o_dout, o_busy, o_pix_ready}, 32'd0);
        step();
        chk("rst_mid_2", {29'd0, o_dout, o_busy, o_pix_ready}, 32'd0);
        rst_n = 1'b1;
        step();
        chk("rst_mid_release", {29'd0, o_dout, o_busy, o_pix_ready}, 32'd0);

        // Random frames, including short ones that underrun.
        for (int f = 0; f < 4; f++) begin
            run_frame(8'($urandom), int'($urandom_range(1, 3)), 1'b0, 1'b0);
        end

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
